// File: rtl/custom_palette_loader.sv
// custom_palette_loader
//   Captures a streamed .pal file (R,G,B byte triplets) into a 64-entry
//   15-bit {B5,G5,R5} palette RAM and serves pixel-rate lookups from it.
//   Optional build macro: PAL_LOADER_ROUND_EN selects round-to-nearest
//   (saturating) 8->5 bit channel conversion instead of truncation.
module custom_palette_loader #(
  parameter int NUM_COLORS = 64,
  parameter int IDX_W      = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             dl_active,
  input  logic             dl_wr,
  input  logic [7:0]       dl_data,
  output logic             dl_wait,
  input  logic             rd_ce,
  input  logic [IDX_W-1:0] rd_color,
  output logic [14:0]      rd_pixel,
  output logic             pal_valid,
  output logic             pal_error
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GET_R = 3'd1,
    GET_G = 3'd2,
    GET_B = 3'd3,
    WRITE = 3'd4,
    DRAIN = 3'd5
  } state_t;

`ifdef PAL_LOADER_ROUND_EN
  localparam logic [8:0] RND_ADD = 9'd4;
`else
  localparam logic [8:0] RND_ADD = 9'd0;
`endif

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COLORS - 1);

  state_t           state_q, state_d;
  logic             dl_active_q;
  logic [IDX_W-1:0] idx_q;
  logic [4:0]       r5_q, g5_q, b5_q;

  logic             lat_r, lat_g, lat_b;
  logic             ram_we;
  logic             idx_clr, idx_inc;
  logic             flags_clr, set_valid, set_error;

  logic [14:0]      ram [NUM_COLORS];

  // 9-bit sum keeps the carry so 0xFC..0xFF saturate to 31 when rounding
  logic [5:0]       dl_q6;
  logic [4:0]       dl_c5;

  // Channel conversion of the incoming download byte
  always_comb begin
    dl_q6 = 6'(({1'b0, dl_data} + RND_ADD) >> 3);
    dl_c5 = dl_q6[5] ? 5'd31 : dl_q6[4:0];
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode and per-state control strobes
  always_comb begin
    state_d   = state_q;
    lat_r     = 1'b0;
    lat_g     = 1'b0;
    lat_b     = 1'b0;
    ram_we    = 1'b0;
    idx_clr   = 1'b0;
    idx_inc   = 1'b0;
    flags_clr = 1'b0;
    set_valid = 1'b0;
    set_error = 1'b0;
    dl_wait   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dl_active && !dl_active_q) begin
          flags_clr = 1'b1;
          idx_clr   = 1'b1;
          // a strobe on the rising cycle is byte 0 of the file
          if (dl_wr) begin
            lat_r   = 1'b1;
            state_d = GET_G;
          end else begin
            state_d = GET_R;
          end
        end
      end
      GET_R: begin
        if (!dl_active) begin
          set_error = 1'b1;
          state_d   = IDLE;
        end else if (dl_wr) begin
          lat_r   = 1'b1;
          state_d = GET_G;
        end
      end
      GET_G: begin
        if (!dl_active) begin
          set_error = 1'b1;
          state_d   = IDLE;
        end else if (dl_wr) begin
          lat_g   = 1'b1;
          state_d = GET_B;
        end
      end
      GET_B: begin
        if (!dl_active) begin
          set_error = 1'b1;
          state_d   = IDLE;
        end else if (dl_wr) begin
          lat_b   = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        dl_wait = 1'b1;
        ram_we  = 1'b1;
        if (!dl_active) begin
          set_error = 1'b1;
          state_d   = IDLE;
        end else if (idx_q == LAST_IDX) begin
          set_valid = 1'b1;
          state_d   = DRAIN;
        end else begin
          idx_inc = 1'b1;
          state_d = GET_R;
        end
      end
      DRAIN: begin
        if (!dl_active) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Download datapath: edge detect, channel latches, entry index, status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dl_active_q <= 1'b0;
      idx_q       <= '0;
      r5_q        <= '0;
      g5_q        <= '0;
      b5_q        <= '0;
      pal_valid   <= 1'b0;
      pal_error   <= 1'b0;
    end else begin
      dl_active_q <= dl_active;
      if (lat_r) r5_q <= dl_c5;
      if (lat_g) g5_q <= dl_c5;
      if (lat_b) b5_q <= dl_c5;
      if (idx_clr)      idx_q <= '0;
      else if (idx_inc) idx_q <= idx_q + 1'b1;
      if (flags_clr) begin
        pal_valid <= 1'b0;
        pal_error <= 1'b0;
      end
      if (set_valid) pal_valid <= 1'b1;
      if (set_error) pal_error <= 1'b1;
    end
  end

  // Palette RAM write port (contents survive reset)
  always_ff @(posedge clk) begin
    if (ram_we) ram[idx_q] <= {b5_q, g5_q, r5_q};
  end

  // Pixel read port; same-cycle write to the same entry returns the old word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   rd_pixel <= '0;
    else if (rd_ce) rd_pixel <= ram[rd_color];
  end

endmodule

// File: tb/tb_custom_palette_loader.sv
// Testbench for custom_palette_loader: table-driven conversion vectors plus
// hand sequences for short/long files, async reset, read-first and stalls.
module tb_custom_palette_loader;

  logic        clk;
  logic        reset_n;
  logic        dl_active;
  logic        dl_wr;
  logic [7:0]  dl_data;
  logic        dl_wait;
  logic        rd_ce;
  logic [5:0]  rd_color;
  logic [14:0] rd_pixel;
  logic        pal_valid;
  logic        pal_error;

  custom_palette_loader #(.NUM_COLORS(64), .IDX_W(6)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .dl_active(dl_active),
    .dl_wr    (dl_wr),
    .dl_data  (dl_data),
    .dl_wait  (dl_wait),
    .rd_ce    (rd_ce),
    .rd_color (rd_color),
    .rd_pixel (rd_pixel),
    .pal_valid(pal_valid),
    .pal_error(pal_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic [14:0] exp;
  } vec_t;

`ifdef PAL_LOADER_ROUND_EN
  localparam logic [14:0] E21 = 15'h2108;  // {8,8,8}
  localparam logic [14:0] E63 = 15'h6318;  // {24,24,24}
`else
  localparam logic [14:0] E21 = 15'h2107;  // {8,8,7}
  localparam logic [14:0] E63 = 15'h5EF7;  // {23,23,23}
`endif

  int          tests = 0;
  int          fails = 0;
  int          nbytes;
  logic [7:0]  mr, mg, mb;
  logic [14:0] model [64];
  logic [14:0] exp_q [$];
  vec_t        vt [6];

  function automatic logic [4:0] conv(input logic [7:0] b);
    int v;
`ifdef PAL_LOADER_ROUND_EN
    v = (int'(b) + 4) / 8;
    if (v > 31) v = 31;
`else
    v = int'(b) / 8;
`endif
    return v[4:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic compare_rd(input string nm);
    logic [14:0] e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: scoreboard empty, got %h", nm, rd_pixel);
    end else begin
      e = exp_q.pop_front();
      check(nm, {17'd0, rd_pixel}, {17'd0, e});
    end
  endtask

  task automatic rd_check(input logic [5:0] idx, input logic [14:0] exp, input string nm);
    rd_ce    = 1'b1;
    rd_color = idx;
    exp_q.push_back(exp);
    tick;
    rd_ce = 1'b0;
    compare_rd(nm);
  endtask

  // mode 0: plain byte; 1: read the entry being written during WRITE;
  // 2: illegal extra strobe during WRITE (must be dropped)
  task automatic send_byte(input logic [7:0] b, input int mode);
    int n;
    bit wexp;
    n = nbytes;
    dl_data = b;
    dl_wr   = 1'b1;
    tick;
    dl_wr = 1'b0;
    if (n < 192) begin
      case (n % 3)
        0: mr = b;
        1: mg = b;
        default: mb = b;
      endcase
    end
    wexp = (n < 192) && (n % 3 == 2);
    check("dl_wait_write", {31'd0, dl_wait}, {31'd0, wexp});
    if (wexp && mode == 1) begin
      rd_ce    = 1'b1;
      rd_color = 6'(n / 3);
      exp_q.push_back(model[n / 3]);
    end
    if (wexp && mode == 2) begin
      dl_data = 8'hA5;
      dl_wr   = 1'b1;
    end
    tick;
    dl_wr = 1'b0;
    rd_ce = 1'b0;
    if (wexp && mode == 1) compare_rd("read_first");
    check("dl_wait_idle", {31'd0, dl_wait}, 32'd0);
    if (wexp) model[n / 3] = {conv(mb), conv(mg), conv(mr)};
    nbytes++;
  endtask

  task automatic start_dl;
    dl_active = 1'b1;
    nbytes    = 0;
    tick;
    check("start_valid_clr", {31'd0, pal_valid}, 32'd0);
    check("start_error_clr", {31'd0, pal_error}, 32'd0);
  endtask

  task automatic end_dl;
    bit full;
    full = (nbytes >= 192);
    dl_active = 1'b0;
    tick;
    check("end_valid", {31'd0, pal_valid}, {31'd0, full});
    check("end_error", {31'd0, pal_error}, {31'd0, !full});
    tick;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0] = '{r: 8'h7C, g: 8'h04, b: 8'hFC, exp: 15'h7C0F};
    vt[1] = '{r: 8'h00, g: 8'h00, b: 8'h00, exp: 15'h0000};
    vt[2] = '{r: 8'hFF, g: 8'hFF, b: 8'hFF, exp: 15'h7FFF};
    vt[3] = '{r: 8'h08, g: 8'h10, b: 8'h18, exp: 15'h0C41};
    vt[4] = '{r: 8'h07, g: 8'h0B, b: 8'hF3, exp: 15'h7820};
    vt[5] = '{r: 8'h84, g: 8'h43, b: 8'h3C, exp: 15'h1D10};
`ifdef PAL_LOADER_ROUND_EN
    vt[0].exp = 15'h7C30;  // {31,1,16}
    vt[4].exp = 15'h7821;  // {30,1,1}
    vt[5].exp = 15'h2111;  // {8,8,17}
`endif

    reset_n   = 1'b0;
    dl_active = 1'b0;
    dl_wr     = 1'b0;
    dl_data   = '0;
    rd_ce     = 1'b0;
    rd_color  = '0;
    nbytes    = 0;
    mr = '0; mg = '0; mb = '0;
    repeat (3) tick;
    check("rst_dl_wait", {31'd0, dl_wait}, 32'd0);
    check("rst_rd_pixel", {17'd0, rd_pixel}, 32'd0);
    check("rst_pal_valid", {31'd0, pal_valid}, 32'd0);
    check("rst_pal_error", {31'd0, pal_error}, 32'd0);
    reset_n = 1'b1;
    tick;

    // T1: full 192-byte load, byte k = k
    start_dl;
    for (int k = 0; k < 192; k++) begin
      send_byte(8'(k), 0);
      if (k == 190) check("t1_valid_before_last", {31'd0, pal_valid}, 32'd0);
    end
    check("t1_valid_after_last", {31'd0, pal_valid}, 32'd1);
    end_dl;
    rd_check(6'd0, 15'h0000, "t1_ram0");
    rd_check(6'd63, E63, "t1_ram63");

    // T2: readback with one-cycle latency, then hold with rd_ce low
    rd_check(6'h15, E21, "t2_ram21");
    rd_color = 6'h3F;
    tick;
    tick;
    check("t2_hold", {17'd0, rd_pixel}, {17'd0, E21});

    // strobes while dl_active is low are ignored
    for (int i = 0; i < 3; i++) begin
      dl_data = 8'h55;
      dl_wr   = 1'b1;
      tick;
      dl_wr = 1'b0;
      tick;
    end
    check("idle_wr_valid", {31'd0, pal_valid}, 32'd1);
    rd_check(6'd5, model[5], "idle_wr_ram5");

    // T3: short file aborts, following full load recovers
    start_dl;
    for (int k = 0; k < 100; k++) send_byte(8'(k * 3 + 200), 0);
    end_dl;
    rd_check(6'd10, model[10], "t3_partial_ram10");
    start_dl;
    for (int k = 0; k < 192; k++) send_byte(8'(k + 17), 0);
    end_dl;
    rd_check(6'd40, model[40], "t3_reload_ram40");

    // T4: long file, dl_wr coincident with dl_active rise is byte 0
    dl_active = 1'b1;
    nbytes    = 0;
    send_byte(8'd3, 0);
    check("t4_rise_valid_clr", {31'd0, pal_valid}, 32'd0);
    for (int k = 1; k < 1536; k++) begin
      if (k < 192) send_byte(8'(k * 7 + 3), 0);
      else         send_byte(8'(k) ^ 8'hC3, 0);
      if (k == 191) check("t4_valid_at_192", {31'd0, pal_valid}, 32'd1);
    end
    end_dl;
    rd_check(6'd0, model[0], "t4_ram0");
    rd_check(6'd30, model[30], "t4_ram30");
    rd_check(6'd63, model[63], "t4_ram63");

    // T5: async reset while in WRITE, then a clean reload
    start_dl;
    for (int k = 0; k < 50; k++) send_byte(8'(k * 3 + 9), 0);
    dl_data = 8'h77;
    dl_wr   = 1'b1;
    tick;
    dl_wr = 1'b0;
    check("t5_wait_pre_reset", {31'd0, dl_wait}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("t5_rst_dl_wait", {31'd0, dl_wait}, 32'd0);
    check("t5_rst_rd_pixel", {17'd0, rd_pixel}, 32'd0);
    check("t5_rst_pal_valid", {31'd0, pal_valid}, 32'd0);
    check("t5_rst_pal_error", {31'd0, pal_error}, 32'd0);
    tick;
    dl_active = 1'b0;
    tick;
    reset_n = 1'b1;
    tick;
    start_dl;
    for (int k = 0; k < 192; k++) send_byte(8'(k * 5 + 1), 0);
    end_dl;
    rd_check(6'd16, model[16], "t5_ram16");
    rd_check(6'd50, model[50], "t5_ram50");

    // T6: conversion table, read-first on entry 3, dropped strobe after entry 2
    start_dl;
    for (int e = 0; e < 64; e++) begin
      if (e < 6) begin
        send_byte(vt[e].r, 0);
        send_byte(vt[e].g, 0);
        send_byte(vt[e].b, (e == 2) ? 2 : (e == 3) ? 1 : 0);
      end else begin
        send_byte(8'(e * 3), 0);
        send_byte(8'(e * 3 + 1), 0);
        send_byte(8'(e * 3 + 2), 0);
      end
    end
    end_dl;
    for (int i = 0; i < 6; i++) rd_check(6'(i), vt[i].exp, $sformatf("t6_vec%0d", i));
    rd_check(6'd6, model[6], "t6_ram6");
    rd_check(6'd63, model[63], "t6_ram63");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
